// File: rtl/inst_aligner.sv
// Instruction aligner between the fetch response path and the decoder.
// Splits RVC halves out of fetch words and stitches straddling 32-bit ones.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   flush, flush_pc   redirect; drops all buffered state, new target PC
//   f_valid/f_ready   fetch word handshake; f_addr word address, f_data word
//   i_valid/i_ready   instruction handshake to decoder
//   i_pc, i_bits      instruction PC and bits (RVC zero-extended)
//   i_is_rvc          instruction is a 16-bit encoding
module inst_aligner #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned     IALIGN   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            f_valid,
    output logic            f_ready,
    input  logic [XLEN-1:0] f_addr,
    input  logic [31:0]     f_data,
    output logic            i_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] i_pc,
    output logic [31:0]     i_bits,
    output logic            i_is_rvc
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HALF_C = 2'd1,
        HALF_L = 2'd2
    } state_t;

    localparam bit              SPLIT     = (IALIGN == 16);
    localparam logic [XLEN-1:0] STEP2     = XLEN'(2);
    localparam logic [XLEN-1:0] STEP4     = XLEN'(4);
    localparam logic [XLEN-1:0] RESET_EXP = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic            RESET_SKP = RESET_PC[1];

    state_t            state_q, state_d;
    logic [15:0]       hbuf_q, hbuf_d;
    logic [XLEN-1:0]   hbuf_pc_q, hbuf_pc_d;
    logic [XLEN-1:0]   exp_q, exp_d;
    logic              skip_q, skip_d;

    logic              emit;
    logic [XLEN-1:0]   emit_pc;
    logic [31:0]       emit_bits;
    logic              emit_rvc;

    logic [15:0]       half_lo;
    logic [15:0]       half_hi;
    logic              lo_c;
    logic              hi_c;
    logic [XLEN-1:0]   hi_pc;
    logic              slot_free;
    logic              stale;
    logic              take;
    logic              unused_bits;

    assign unused_bits = flush_pc[0];

    assign half_lo   = f_data[15:0];
    assign half_hi   = f_data[31:16];
    assign lo_c      = (half_lo[1:0] != 2'b11);
    assign hi_c      = (half_hi[1:0] != 2'b11);
    assign hi_pc     = f_addr + STEP2;
    assign slot_free = !i_valid || i_ready;

    // Responses for an address we are not expecting are left over from
    // before a redirect; swallow them unconditionally so fetch never stalls.
    assign stale   = f_valid && (f_addr != exp_q);
    assign f_ready = (slot_free && (state_q != HALF_C) && !flush) || stale;
    assign take    = f_valid && f_ready && !stale;

    always_comb begin
        state_d   = state_q;
        hbuf_d    = hbuf_q;
        hbuf_pc_d = hbuf_pc_q;
        exp_d     = exp_q;
        skip_d    = skip_q;
        emit      = 1'b0;
        emit_pc   = f_addr;
        emit_bits = f_data;
        emit_rvc  = 1'b0;

        if (flush) begin
            state_d = EMPTY;
            exp_d   = {flush_pc[XLEN-1:2], 2'b00};
            skip_d  = flush_pc[1];
        end else if (state_q == HALF_C) begin
            // Drain the buffered RVC instruction; no fetch word needed.
            if (slot_free) begin
                emit      = 1'b1;
                emit_pc   = hbuf_pc_q;
                emit_bits = {16'h0, hbuf_q};
                emit_rvc  = 1'b1;
                state_d   = EMPTY;
            end
        end else if (take) begin
            exp_d = exp_q + STEP4;
            if (!SPLIT) begin
                emit      = 1'b1;
                emit_pc   = f_addr;
                emit_bits = f_data;
                emit_rvc  = lo_c;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (skip_q) begin
                            // Redirect into the upper half: low half is dead.
                            skip_d = 1'b0;
                            if (hi_c) begin
                                emit      = 1'b1;
                                emit_pc   = hi_pc;
                                emit_bits = {16'h0, half_hi};
                                emit_rvc  = 1'b1;
                            end else begin
                                hbuf_d    = half_hi;
                                hbuf_pc_d = hi_pc;
                                state_d   = HALF_L;
                            end
                        end else if (lo_c) begin
                            emit      = 1'b1;
                            emit_pc   = f_addr;
                            emit_bits = {16'h0, half_lo};
                            emit_rvc  = 1'b1;
                            hbuf_d    = half_hi;
                            hbuf_pc_d = hi_pc;
                            state_d   = hi_c ? HALF_C : HALF_L;
                        end else begin
                            emit      = 1'b1;
                            emit_pc   = f_addr;
                            emit_bits = f_data;
                            emit_rvc  = 1'b0;
                        end
                    end
                    HALF_L: begin
                        // Upper half of the straddling instruction is lo.
                        emit      = 1'b1;
                        emit_pc   = hbuf_pc_q;
                        emit_bits = {half_lo, hbuf_q};
                        emit_rvc  = 1'b0;
                        hbuf_d    = half_hi;
                        hbuf_pc_d = hi_pc;
                        state_d   = hi_c ? HALF_C : HALF_L;
                    end
                    default: begin
                        state_d = EMPTY;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            hbuf_q    <= 16'h0;
            hbuf_pc_q <= '0;
            exp_q     <= RESET_EXP;
            skip_q    <= RESET_SKP;
        end else begin
            state_q   <= state_d;
            hbuf_q    <= hbuf_d;
            hbuf_pc_q <= hbuf_pc_d;
            exp_q     <= exp_d;
            skip_q    <= skip_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_valid  <= 1'b0;
            i_pc     <= '0;
            i_bits   <= 32'h0;
            i_is_rvc <= 1'b0;
        end else if (flush) begin
            i_valid <= 1'b0;
        end else if (slot_free) begin
            i_valid <= emit;
            if (emit) begin
                i_pc     <= emit_pc;
                i_bits   <= emit_bits;
                i_is_rvc <= emit_rvc;
            end
        end
    end

endmodule

// File: tb/tb_inst_aligner.sv
// Directed self-checking bench for inst_aligner.
// Each task drives one scenario and checks outputs inline.
module tb_inst_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [63:0] flush_pc;
    logic        f_valid;
    logic        f_ready;
    logic [63:0] f_addr;
    logic [31:0] f_data;
    logic        i_valid;
    logic        i_ready;
    logic [63:0] i_pc;
    logic [31:0] i_bits;
    logic        i_is_rvc;

    int n_checks = 0;
    int n_fails  = 0;

    wire [97:0] obs = {i_valid, i_pc, i_bits, i_is_rvc};

    always #5 clk = ~clk;

    inst_aligner dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .flush_pc (flush_pc),
        .f_valid  (f_valid),
        .f_ready  (f_ready),
        .f_addr   (f_addr),
        .f_data   (f_data),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_pc     (i_pc),
        .i_bits   (i_bits),
        .i_is_rvc (i_is_rvc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        flush    = 1'b0;
        flush_pc = '0;
        f_valid  = 1'b0;
        f_addr   = '0;
        f_data   = '0;
        i_ready  = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 98'h0) begin
            n_fails++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        rst    = 1'b0;
        f_addr = 64'h8000_0000;
        #1;
        n_checks++;
        if (f_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_f_ready: got %b expected 1", f_ready);
        end
    endtask

    task automatic test_word32();
        do_reset();
        f_valid = 1'b1;
        f_addr  = 64'h8000_0000;
        f_data  = 32'h0000_0513;
        #1;
        n_checks++;
        if (f_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL w32_f_ready: got %b expected 1", f_ready);
        end
        tick();
        f_valid = 1'b0;
        n_checks++;
        if (obs !== {1'b1, 64'h8000_0000, 32'h0000_0513, 1'b0}) begin
            n_fails++;
            $display("FAIL w32_out: got %h expected %h", obs,
                     {1'b1, 64'h8000_0000, 32'h0000_0513, 1'b0});
        end
        tick();
        n_checks++;
        if (i_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL w32_idle: got %b expected 0", i_valid);
        end
    endtask

    task automatic test_rvc_pair();
        do_reset();
        f_valid = 1'b1;
        f_addr  = 64'h8000_0000;
        f_data  = 32'h4501_4505;
        tick();
        f_valid = 1'b0;
        #1;
        n_checks++;
        if (obs !== {1'b1, 64'h8000_0000, 32'h0000_4505, 1'b1}) begin
            n_fails++;
            $display("FAIL pair_lo: got %h expected %h", obs,
                     {1'b1, 64'h8000_0000, 32'h0000_4505, 1'b1});
        end
        n_checks++;
        if (f_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL pair_drain_f_ready: got %b expected 0", f_ready);
        end
        tick();
        n_checks++;
        if (obs !== {1'b1, 64'h8000_0002, 32'h0000_4501, 1'b1}) begin
            n_fails++;
            $display("FAIL pair_hi: got %h expected %h", obs,
                     {1'b1, 64'h8000_0002, 32'h0000_4501, 1'b1});
        end
        n_checks++;
        if (f_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL pair_after_f_ready: got %b expected 1", f_ready);
        end
        tick();
        n_checks++;
        if (i_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL pair_idle: got %b expected 0", i_valid);
        end
    endtask

    task automatic test_straddle();
        do_reset();
        f_valid = 1'b1;
        f_addr  = 64'h8000_0000;
        f_data  = 32'h0513_4505;
        tick();
        n_checks++;
        if (obs !== {1'b1, 64'h8000_0000, 32'h0000_4505, 1'b1}) begin
            n_fails++;
            $display("FAIL strad_first: got %h expected %h", obs,
                     {1'b1, 64'h8000_0000, 32'h0000_4505, 1'b1});
        end
        f_addr = 64'h8000_0004;
        f_data = 32'h4501_0000;
        #1;
        n_checks++;
        if (f_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL strad_f_ready: got %b expected 1", f_ready);
        end
        tick();
        f_valid = 1'b0;
        n_checks++;
        if (obs !== {1'b1, 64'h8000_0002, 32'h0000_0513, 1'b0}) begin
            n_fails++;
            $display("FAIL strad_joined: got %h expected %h", obs,
                     {1'b1, 64'h8000_0002, 32'h0000_0513, 1'b0});
        end
        tick();
        n_checks++;
        if (obs !== {1'b1, 64'h8000_0006, 32'h0000_4501, 1'b1}) begin
            n_fails++;
            $display("FAIL strad_tail: got %h expected %h", obs,
                     {1'b1, 64'h8000_0006, 32'h0000_4501, 1'b1});
        end
        tick();
        n_checks++;
        if (i_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL strad_idle: got %b expected 0", i_valid);
        end
    endtask

    task automatic test_flush_stale();
        do_reset();
        flush    = 1'b1;
        flush_pc = 64'h8000_0102;
        tick();
        flush = 1'b0;
        n_checks++;
        if (i_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL fl_after: got %b expected 0", i_valid);
        end
        f_valid = 1'b1;
        f_addr  = 64'h8000_0010;
        f_data  = 32'h0000_0513;
        #1;
        n_checks++;
        if (f_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL fl_stale_ready: got %b expected 1", f_ready);
        end
        tick();
        n_checks++;
        if (i_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL fl_stale_drop: got %b expected 0", i_valid);
        end
        f_addr = 64'h8000_0100;
        f_data = 32'h4505_1234;
        tick();
        f_valid = 1'b0;
        n_checks++;
        if (obs !== {1'b1, 64'h8000_0102, 32'h0000_4505, 1'b1}) begin
            n_fails++;
            $display("FAIL fl_target: got %h expected %h", obs,
                     {1'b1, 64'h8000_0102, 32'h0000_4505, 1'b1});
        end
        tick();
        n_checks++;
        if (i_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL fl_idle: got %b expected 0", i_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        i_ready = 1'b0;
        f_valid = 1'b1;
        f_addr  = 64'h8000_0000;
        f_data  = 32'h4501_4505;
        tick();
        f_addr = 64'h8000_0004;
        f_data = 32'h0000_0513;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (obs !== {1'b1, 64'h8000_0000, 32'h0000_4505, 1'b1} ||
                f_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL bp_hold%0d: got %h/%b expected %h/0", c,
                         obs, f_ready,
                         {1'b1, 64'h8000_0000, 32'h0000_4505, 1'b1});
            end
            tick();
        end
        i_ready = 1'b1;
        #1;
        n_checks++;
        if (f_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL bp_drain_ready: got %b expected 0", f_ready);
        end
        tick();
        n_checks++;
        if (obs !== {1'b1, 64'h8000_0002, 32'h0000_4501, 1'b1}) begin
            n_fails++;
            $display("FAIL bp_second: got %h expected %h", obs,
                     {1'b1, 64'h8000_0002, 32'h0000_4501, 1'b1});
        end
        tick();
        f_valid = 1'b0;
        n_checks++;
        if (obs !== {1'b1, 64'h8000_0004, 32'h0000_0513, 1'b0}) begin
            n_fails++;
            $display("FAIL bp_third: got %h expected %h", obs,
                     {1'b1, 64'h8000_0004, 32'h0000_0513, 1'b0});
        end
        tick();
        n_checks++;
        if (i_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL bp_idle: got %b expected 0", i_valid);
        end
    endtask

    task automatic test_flush_half_l();
        do_reset();
        i_ready = 1'b0;
        f_valid = 1'b1;
        f_addr  = 64'h8000_0000;
        f_data  = 32'h0513_4505;
        tick();
        f_valid  = 1'b0;
        flush    = 1'b1;
        flush_pc = 64'h8000_0200;
        tick();
        flush = 1'b0;
        n_checks++;
        if (i_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL fhl_after: got %b expected 0", i_valid);
        end
        i_ready = 1'b1;
        f_valid = 1'b1;
        f_addr  = 64'h8000_0200;
        f_data  = 32'h0000_0593;
        tick();
        f_valid = 1'b0;
        n_checks++;
        if (obs !== {1'b1, 64'h8000_0200, 32'h0000_0593, 1'b0}) begin
            n_fails++;
            $display("FAIL fhl_first: got %h expected %h", obs,
                     {1'b1, 64'h8000_0200, 32'h0000_0593, 1'b0});
        end
        tick();
        n_checks++;
        if (i_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL fhl_idle: got %b expected 0", i_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        flush    = 1'b1;
        flush_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        flush   = 1'b0;
        f_valid = 1'b1;
        f_addr  = 64'hFFFF_FFFF_FFFF_FFFC;
        f_data  = 32'h4505_0000;
        tick();
        n_checks++;
        if (obs !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0000_4505, 1'b1}) begin
            n_fails++;
            $display("FAIL wrap_top: got %h expected %h", obs,
                     {1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0000_4505, 1'b1});
        end
        f_addr = 64'h0;
        f_data = 32'h0000_0513;
        tick();
        f_valid = 1'b0;
        n_checks++;
        if (obs !== {1'b1, 64'h0, 32'h0000_0513, 1'b0}) begin
            n_fails++;
            $display("FAIL wrap_zero: got %h expected %h", obs,
                     {1'b1, 64'h0, 32'h0000_0513, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_ready = 1'b0;
        f_valid = 1'b1;
        f_addr  = 64'h8000_0000;
        f_data  = 32'h4501_4505;
        tick();
        f_valid = 1'b0;
        rst     = 1'b1;
        #1;
        n_checks++;
        if (obs !== 98'h0) begin
            n_fails++;
            $display("FAIL rmid_outputs: got %h expected 0", obs);
        end
        tick();
        rst     = 1'b0;
        i_ready = 1'b1;
        tick();
        n_checks++;
        if (i_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL rmid_lost: got %b expected 0", i_valid);
        end
        f_valid = 1'b1;
        f_addr  = 64'h8000_0000;
        f_data  = 32'h0000_0513;
        tick();
        f_valid = 1'b0;
        n_checks++;
        if (obs !== {1'b1, 64'h8000_0000, 32'h0000_0513, 1'b0}) begin
            n_fails++;
            $display("FAIL rmid_restart: got %h expected %h", obs,
                     {1'b1, 64'h8000_0000, 32'h0000_0513, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_word32();
        test_rvc_pair();
        test_straddle();
        test_flush_stale();
        test_backpressure();
        test_flush_half_l();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
